// File: rtl/bg_pkg.sv
// Shared constants for the background layer sequencer: register map, CTRL
// bit positions, FSM encoding and the layer rotation helper.
package bg_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_DWELL   = 2'd1;
  localparam logic [1:0] ADDR_SPEED_X = 2'd2;
  localparam logic [1:0] ADDR_SPEED_Y = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_MASK_LO = 2;
  localparam int CTRL_MASK_HI = 4;
  localparam logic [7:0] CTRL_WMASK = 8'h1F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] layer_idx;
    logic [7:0] dwell_cnt;
    logic [7:0] ctrl;
    logic [7:0] dwell;
    logic [7:0] speed_x;
    logic [7:0] speed_y;
  } bg_dbg_t;

  // First set mask bit after cur in rotation order 0->1->2->0; cur if none.
  function automatic logic [1:0] next_layer(input logic [2:0] mask, input logic [1:0] cur);
    logic [1:0] res;
    int         i;
    res = cur;
    for (int k = 3; k >= 1; k--) begin
      i = (int'(cur) + k) % 3;
      if (mask[i]) res = 2'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/scroll_wrap_add.sv
// Adds a signed 8-bit step to a scroll offset and wraps it into [0, MOD-1].
module scroll_wrap_add #(
  parameter int MOD = 640
) (
  input  logic [9:0] value,
  input  logic [7:0] step,
  output logic [9:0] result
);

  localparam logic signed [11:0] MOD_S = 12'(MOD);

  logic signed [11:0] sum;

  // |step| <= 128 is below any useful modulus, so one correction suffices.
  always_comb begin
    sum    = signed'({2'b00, value}) + signed'({{4{step[7]}}, step});
    result = sum[9:0];
    if (sum < 0) begin
      result = 10'(sum + MOD_S);
    end else if (sum >= MOD_S) begin
      result = 10'(sum - MOD_S);
    end
  end

endmodule

// File: rtl/bg_layer_sequencer.sv
// Background layer sequencer: staged config registers copied to active on
// each vsync rising edge, layer rotation with dwell, and wrapping scroll.
module bg_layer_sequencer
  import bg_pkg::*;
#(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  input  logic       vsync,
  output logic       vga_en,
  output logic [2:0] layer_en,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y,
  output logic       irq,
  input  logic       irq_clr,
  output bg_dbg_t    dbg
);

  logic [7:0] ctrl_s, dwell_s, spd_x_s, spd_y_s;
  logic [7:0] ctrl_a, dwell_a, spd_x_a, spd_y_a;
  logic       vsync_q, vs_low_seen, tick;
  state_t     state, state_nxt;
  logic [1:0] layer_idx, idx_nxt;
  logic [7:0] dwell_cnt, cnt_nxt, dwell_last;
  logic [2:0] stg_mask;
  logic       stg_ok, load, clr_scroll, step_scroll, switch_evt;
  logic [9:0] scroll_x_nxt, scroll_y_nxt;

  // A tick needs vsync seen low since reset, so a vsync held high across
  // reset release cannot fire one.
  assign tick       = vsync & ~vsync_q & vs_low_seen;
  assign stg_mask   = ctrl_s[CTRL_MASK_HI:CTRL_MASK_LO];
  assign stg_ok     = ctrl_s[CTRL_RUN] && (stg_mask != 3'b000);
  assign dwell_last = (dwell_s == 8'd0) ? 8'd0 : dwell_s - 8'd1;

  always_comb begin
    case (cfg_addr)
      ADDR_CTRL:    cfg_rdata = ctrl_s & CTRL_WMASK;
      ADDR_DWELL:   cfg_rdata = dwell_s;
      ADDR_SPEED_X: cfg_rdata = spd_x_s;
      default:      cfg_rdata = spd_y_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_s      <= '0;
      dwell_s     <= '0;
      spd_x_s     <= '0;
      spd_y_s     <= '0;
      vsync_q     <= 1'b0;
      vs_low_seen <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      vs_low_seen <= vs_low_seen | ~vsync;
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_CTRL:    ctrl_s  <= cfg_wdata & CTRL_WMASK;
          ADDR_DWELL:   dwell_s <= cfg_wdata;
          ADDR_SPEED_X: spd_x_s <= cfg_wdata;
          default:      spd_y_s <= cfg_wdata;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Tick-time decisions use the staged values being copied to active.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = layer_idx;
    cnt_nxt     = dwell_cnt;
    load        = 1'b0;
    clr_scroll  = 1'b0;
    step_scroll = 1'b0;
    switch_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (stg_ok) begin
          state_nxt  = ST_ARM;
          clr_scroll = 1'b1;
        end
      end
      ST_ARM: begin
        if (tick) begin
          load = 1'b1;
          if (!stg_ok) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_SHOW;
            idx_nxt   = next_layer(stg_mask, 2'd2);
            cnt_nxt   = 8'd0;
          end
        end
      end
      ST_SHOW: begin
        if (tick) begin
          load        = 1'b1;
          step_scroll = 1'b1;
          if (!stg_ok) begin
            state_nxt = ST_IDLE;
          end else if (!stg_mask[layer_idx] ||
                       (ctrl_s[CTRL_AUTO] && dwell_cnt >= dwell_last)) begin
            idx_nxt    = next_layer(stg_mask, layer_idx);
            cnt_nxt    = 8'd0;
            switch_evt = (idx_nxt != layer_idx);
          end else begin
            cnt_nxt = dwell_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  scroll_wrap_add #(.MOD(FRAME_W)) u_wrap_x (
    .value  (scroll_x),
    .step   (spd_x_s),
    .result (scroll_x_nxt)
  );

  scroll_wrap_add #(.MOD(FRAME_H)) u_wrap_y (
    .value  (scroll_y),
    .step   (spd_y_s),
    .result (scroll_y_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_a    <= '0;
      dwell_a   <= '0;
      spd_x_a   <= '0;
      spd_y_a   <= '0;
      layer_idx <= '0;
      dwell_cnt <= '0;
      vga_en    <= 1'b0;
      layer_en  <= 3'b000;
      scroll_x  <= '0;
      scroll_y  <= '0;
      irq       <= 1'b0;
    end else begin
      if (load) begin
        ctrl_a  <= ctrl_s;
        dwell_a <= dwell_s;
        spd_x_a <= spd_x_s;
        spd_y_a <= spd_y_s;
      end
      layer_idx <= idx_nxt;
      dwell_cnt <= cnt_nxt;
      vga_en    <= (state_nxt != ST_IDLE);
      layer_en  <= (state_nxt == ST_SHOW) ? (3'b001 << idx_nxt) : 3'b000;
      if (clr_scroll) begin
        scroll_x <= '0;
        scroll_y <= '0;
      end else if (step_scroll) begin
        scroll_x <= scroll_x_nxt;
        scroll_y <= scroll_y_nxt;
      end
      if (switch_evt)   irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

  always_comb begin
    dbg           = '0;
    dbg.state     = state;
    dbg.layer_idx = layer_idx;
    dbg.dwell_cnt = dwell_cnt;
    dbg.ctrl      = ctrl_a;
    dbg.dwell     = dwell_a;
    dbg.speed_x   = spd_x_a;
    dbg.speed_y   = spd_y_a;
  end

endmodule

// File: tb/tb_bg_layer_sequencer.sv
// Bench for bg_layer_sequencer: directed scenarios plus random traffic,
// every output compared each cycle against a frame-level reference model.
module tb_bg_layer_sequencer;
  import bg_pkg::*;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int P_OFF  = 0;
  localparam int P_WAIT = 1;
  localparam int P_ON   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'd0;
  logic [7:0] cfg_rdata;
  logic       vsync = 1'b0;
  logic       vga_en;
  logic [2:0] layer_en;
  logic [9:0] scroll_x, scroll_y;
  logic       irq;
  logic       irq_clr = 1'b0;
  bg_dbg_t    dbg;

  bg_layer_sequencer #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .vsync     (vsync),
    .vga_en    (vga_en),
    .layer_en  (layer_en),
    .scroll_x  (scroll_x),
    .scroll_y  (scroll_y),
    .irq       (irq),
    .irq_clr   (irq_clr),
    .dbg       (dbg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_phase, m_layer, m_frames, m_sx, m_sy, m_dw, m_nl;
  bit         m_irq, m_vs_prev, m_seen_low, m_tick, m_ok, m_sw;
  logic [2:0] m_mask;
  logic [7:0] m_reg [4];

  function automatic int next_on(input logic [2:0] mask, input int cur);
    for (int k = 1; k <= 3; k++) begin
      if (mask[(cur + k) % 3]) return (cur + k) % 3;
    end
    return cur;
  endfunction

  function automatic int wrap(input int v, input int d, input int m);
    int r;
    r = (v + d) % m;
    if (r < 0) r += m;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_OFF; m_layer = 0; m_frames = 0; m_sx = 0; m_sy = 0;
      m_irq = 0; m_vs_prev = 0; m_seen_low = 0;
      for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
    end else begin
      m_tick = vsync && !m_vs_prev && m_seen_low;
      m_vs_prev = vsync;
      if (!vsync) m_seen_low = 1;
      m_mask = m_reg[0][4:2];
      m_ok = m_reg[0][0] && (m_mask != 3'b000);
      m_dw = (m_reg[1] == 8'd0) ? 1 : int'(m_reg[1]);
      m_sw = 0;
      if (m_phase == P_OFF) begin
        if (m_ok) begin m_phase = P_WAIT; m_sx = 0; m_sy = 0; end
      end else if (m_tick) begin
        if (m_phase == P_ON) begin
          m_sx = wrap(m_sx, int'($signed(m_reg[2])), FRAME_W);
          m_sy = wrap(m_sy, int'($signed(m_reg[3])), FRAME_H);
        end
        if (!m_ok) begin
          m_phase = P_OFF;
        end else if (m_phase == P_WAIT) begin
          m_phase = P_ON; m_layer = next_on(m_mask, 2); m_frames = 1;
        end else if (!m_mask[m_layer] || (m_reg[0][1] && m_frames >= m_dw)) begin
          m_nl = next_on(m_mask, m_layer);
          m_sw = (m_nl != m_layer);
          m_layer = m_nl;
          m_frames = 1;
        end else begin
          m_frames++;
        end
      end
      if (m_sw) m_irq = 1;
      else if (irq_clr) m_irq = 0;
      if (cfg_we) m_reg[cfg_addr] = (cfg_addr == 2'd0) ? (cfg_wdata & 8'h1F) : cfg_wdata;
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("vga_en",    vga_en,    32'(m_phase != P_OFF));
      check("layer_en",  layer_en,  (m_phase == P_ON) ? (32'd1 << m_layer) : 32'd0);
      check("scroll_x",  scroll_x,  32'(m_sx));
      check("scroll_y",  scroll_y,  32'(m_sy));
      check("irq",       irq,       32'(m_irq));
      check("cfg_rdata", cfg_rdata, 32'(m_reg[cfg_addr]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    vsync = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic frame(input int lo, input int hi, input bit clr_at_tick = 1'b0);
    vsync = 1'b0;
    cyc(lo);
    vsync = 1'b1;
    irq_clr = clr_at_tick;
    cyc(1);
    irq_clr = 1'b0;
    if (hi > 1) cyc(hi - 1);
    vsync = 1'b0;
  endtask

  task automatic pulse_clr();
    irq_clr = 1'b1;
    cyc(1);
    irq_clr = 1'b0;
  endtask

  int exp_layer [10] = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 1};
  int exp_irq   [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  logic [7:0] rd;

  initial begin
    do_reset();
    mon_en = 1'b1;
    check("rst_vga_en", vga_en, 0);
    check("rst_layer_en", layer_en, 0);
    check("rst_irq", irq, 0);

    // Single-layer auto-cycle: one vsync shows dunes, no interrupt.
    wr(ADDR_CTRL, 8'h07);
    wr(ADDR_DWELL, 8'h02);
    cfg_addr = ADDR_CTRL;
    cyc(1);
    check("ctrl_readback", cfg_rdata, 8'h07);
    frame(2, 2);
    check("single_layer_en", layer_en, 3'b001);
    check("single_vga_en", vga_en, 1);
    check("single_irq", irq, 0);

    // Three-layer rotation with dwell 3.
    do_reset();
    wr(ADDR_CTRL, 8'h1F);
    wr(ADDR_DWELL, 8'h03);
    for (int f = 0; f < 10; f++) begin
      frame(2, 2);
      check($sformatf("rot_layer_f%0d", f), layer_en, exp_layer[f]);
      check($sformatf("rot_irq_f%0d", f), irq, exp_irq[f]);
      pulse_clr();
    end

    // Scroll wrap for negative and positive speeds.
    do_reset();
    wr(ADDR_CTRL, 8'h05);
    frame(2, 1);
    wr(ADDR_SPEED_X, 8'h02);
    wr(ADDR_SPEED_Y, 8'hFB);
    frame(2, 1);
    check("scroll_x_2", scroll_x, 2);
    check("scroll_y_475", scroll_y, 475);
    wr(ADDR_SPEED_X, 8'hFB);
    wr(ADDR_SPEED_Y, 8'h0A);
    frame(2, 1);
    check("scroll_x_637", scroll_x, 637);
    check("scroll_y_5", scroll_y, 5);

    // Mid-frame CTRL write takes effect only at the next vsync edge.
    wr(ADDR_CTRL, 8'h09);
    cyc(3);
    check("midframe_layer_hold", layer_en, 3'b001);
    check("midframe_scroll_hold", scroll_x, 637);
    frame(1, 1);
    check("midframe_layer_new", layer_en, 3'b010);
    check("midframe_irq", irq, 1);

    // Clear coinciding with a switch: set wins.
    do_reset();
    wr(ADDR_CTRL, 8'h0F);
    wr(ADDR_DWELL, 8'h01);
    frame(2, 1);
    check("clr_pre_layer", layer_en, 3'b001);
    frame(2, 1, 1'b1);
    check("clr_set_wins_irq", irq, 1);
    check("clr_set_wins_layer", layer_en, 3'b010);

    // Reset in SHOW with vsync high; no tick until a fresh rising edge.
    do_reset();
    wr(ADDR_CTRL, 8'h05);
    frame(2, 1);
    vsync = 1'b0;
    cyc(1);
    vsync = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #1;
    check("async_rst_vga_en", vga_en, 0);
    check("async_rst_layer_en", layer_en, 0);
    check("async_rst_scroll_x", scroll_x, 0);
    check("async_rst_irq", irq, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    wr(ADDR_CTRL, 8'h05);
    cyc(3);
    check("no_stale_tick_vga", vga_en, 1);
    check("no_stale_tick_layer", layer_en, 0);
    vsync = 1'b0;
    cyc(1);
    vsync = 1'b1;
    cyc(1);
    check("fresh_tick_layer", layer_en, 3'b001);
    vsync = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          cfg_addr = 2'($urandom_range(0, 3));
          if (cfg_addr == ADDR_CTRL) begin
            rd = 8'($urandom_range(0, 255));
            rd[0] = ($urandom_range(0, 9) != 0);
            wr(ADDR_CTRL, rd);
          end else if (cfg_addr == ADDR_DWELL) begin
            wr(ADDR_DWELL, 8'($urandom_range(0, 4)));
          end else begin
            wr(cfg_addr, 8'($urandom_range(0, 255)));
          end
        end
        3, 4, 5, 6: frame($urandom_range(1, 4), $urandom_range(1, 3), 1'($urandom_range(0, 3) == 0));
        7: pulse_clr();
        8: begin
          cfg_addr = 2'($urandom_range(0, 3));
          cyc($urandom_range(1, 3));
        end
        default: if ($urandom_range(0, 3) == 0) do_reset(); else cyc(1);
      endcase
    end

    cyc(2);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
